pixel_frame_buffer: RTL

- Ping-pong image buffer directly upstream of the layer-1 neuron datapath; replaces the fixed test-image ROM.
- Accepts a byte-wide pixel stream (valid/ready, start-of-frame marked) and stores 784-pixel frames into two banks.
- Presents the completed bank to the inference controller through the same addr -> output_value read interface as the test-image ROM (1-cycle latency, 32-bit signed).
- The next frame fills while the current one is being classified.

---
 rtl/pixel_frame_buffer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/pixel_frame_buffer.sv
// Ping-pong frame store ahead of the layer-1 neuron datapath: a byte-wide pixel stream
// fills one bank while the inference controller reads the other through a 1-cycle addr port.
module pixel_frame_buffer #(
    parameter int NUM_PIXELS = 784,
    parameter int ADDR_W     = 12,
    parameter int PIX_W      = 8,
    parameter int DATA_W     = 32,
    parameter int FRAC_SHIFT = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [PIX_W-1:0]         in_data,
    input  logic                     in_sof,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        addr,
    output logic signed [DATA_W-1:0] output_value,
    output logic                     frame_valid,
    input  logic                     frame_done,
    output logic                     sync_err,
    output logic [7:0]               frame_count
);
    localparam int MEM_DEPTH = 2 * NUM_PIXELS;
    localparam int MEM_AW    = $clog2(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PIX   = ADDR_W'(NUM_PIXELS - 1);
    localparam logic [ADDR_W-1:0] PIX_LIMIT  = ADDR_W'(NUM_PIXELS);
    localparam logic [MEM_AW-1:0] BANK1_BASE = MEM_AW'(NUM_PIXELS);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_WAIT} wr_state_e;

    wr_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [1:0]        full_q, full_d;
    logic              in_ready_q, in_ready_d;
    logic              sync_err_q, sync_err_d;
    logic [7:0]        frame_count_q, frame_count_d;

    logic              accept;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [MEM_AW-1:0] wr_idx, rd_idx;
    logic              rd_in_range;
    logic              addr_ok_q;
    logic [PIX_W-1:0]  pix_q;
    logic [PIX_W-1:0]  mem [MEM_DEPTH];

    assign accept = in_valid & in_ready_q;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch can infer a latch.
        state_d       = state_q;
        pix_cnt_d     = pix_cnt_q;
        wr_bank_d     = wr_bank_q;
        rd_bank_d     = rd_bank_q;
        full_d        = full_q;
        sync_err_d    = sync_err_q;
        frame_count_d = frame_count_q;
        wr_en         = 1'b0;
        wr_addr       = '0;

        unique case (state_q)
            S_IDLE: begin
                if (full_q[wr_bank_q]) begin
                    state_d = S_WAIT;
                end else if (accept) begin
                    if (in_sof) begin
                        wr_en     = 1'b1;
                        pix_cnt_d = ADDR_W'(1);
                        state_d   = S_FILL;
                    end else begin
                        sync_err_d = 1'b1;
                    end
                end
            end
            S_FILL: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (in_sof) begin
                        // A fresh start-of-frame abandons the partial frame and refills from pixel 0.
                        pix_cnt_d  = ADDR_W'(1);
                        sync_err_d = 1'b1;
                    end else begin
                        wr_addr = pix_cnt_q;
                        if (pix_cnt_q == LAST_PIX) begin
                            full_d[wr_bank_q] = 1'b1;
                            wr_bank_d         = ~wr_bank_q;
                            frame_count_d     = frame_count_q + 8'd1;
                            pix_cnt_d         = '0;
                            state_d           = S_IDLE;
                        end else begin
                            pix_cnt_d = pix_cnt_q + ADDR_W'(1);
                        end
                    end
                end
            end
            S_WAIT: begin
                if (!full_q[wr_bank_q]) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (frame_done && full_q[rd_bank_q]) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end

        // Ready is registered from next-state values so it never sees in_valid combinationally.
        in_ready_d = (state_d != S_WAIT) && !full_d[wr_bank_d];
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register updating from pre-edge values.
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pix_cnt_q     <= '0;
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b0;
            full_q        <= '0;
            in_ready_q    <= 1'b0;
            sync_err_q    <= 1'b0;
            frame_count_q <= '0;
            addr_ok_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pix_cnt_q     <= pix_cnt_d;
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            full_q        <= full_d;
            in_ready_q    <= in_ready_d;
            sync_err_q    <= sync_err_d;
            frame_count_q <= frame_count_d;
            addr_ok_q     <= rd_in_range;
        end
    end

    assign rd_in_range = (addr < PIX_LIMIT);
    assign wr_idx      = (wr_bank_q ? BANK1_BASE : '0) + MEM_AW'(wr_addr);
    assign rd_idx      = rd_in_range ? ((rd_bank_q ? BANK1_BASE : '0) + MEM_AW'(addr)) : '0;

    // NOTE: the pixel RAM is deliberately not reset so it maps onto block RAM; addr_ok_q masks its output instead.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= in_data;
        pix_q <= mem[rd_idx];
    end

    assign output_value = addr_ok_q ? $signed(DATA_W'(pix_q) << FRAC_SHIFT) : '0;
    assign in_ready     = in_ready_q;
    assign frame_valid  = full_q[rd_bank_q];
    assign sync_err     = sync_err_q;
    assign frame_count  = frame_count_q;

endmodule
